p2_pool_ctrl: RTL
=================

// Module: p2_pool_ctrl
// PURPOSE
//  Sequencer for the pooling-2 layer. On start, walks the conv-2 output map
//  (IN_DIM x IN_DIM, row-major) in 2x2 windows, takes the signed max of each
//  window, and writes one result per window to the P2 output memory
//  (OUT_DIM x OUT_DIM, addresses 0..15). Sits between the conv-2 output RAM
//  (read port) and the P2 output RAM (write port). Signals done to the top FSM.
// PARAMETERS
//  IN_DIM   8   conv-2 feature-map side; must equal 2*OUT_DIM
//  OUT_DIM  4   pooled map side; output addresses 0..OUT_DIM^2-1
//  DATA_W   16  pixel width, two's-complement signed
//  RD_LAT   1   read latency in cycles, rd_en to rd_data valid (1..3)
// PORTS
//  clk      in   1        clock
//  reset    in   1        synchronous, active-high
//  start    in   1        one-cycle pulse; begin pooling pass
//  busy     out  1        high from the cycle after accepted start until done rises
//  done     out  1        level; high after last write, cleared by next accepted start
//  rd_en    out  1        conv-2 RAM read strobe
//  rd_addr  out  6        conv-2 RAM address, row*IN_DIM+col
//  rd_data  in   DATA_W   conv-2 RAM data, valid RD_LAT cycles after rd_en
//  wr_en    out  1        P2 RAM write strobe, single cycle per window
//  wr_addr  out  4        P2 RAM address, r*OUT_DIM+c
//  wr_data  out  DATA_W   pooled value
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0,
//    wr_addr=0, wr_data=0, window counters r=c=0, accumulator cleared.
//  - States: IDLE -> READ (start) -> DRAIN -> WRITE -> READ (next window)
//    or DONE (last window written). DONE -> READ on start; otherwise holds.
//  - start is accepted only in IDLE or DONE; ignored while busy.
//  - READ: 4 consecutive cycles, rd_en=1, rd_addr = base, base+1,
//    base+IN_DIM, base+IN_DIM+1, base=(2r)*IN_DIM+2c.
//  - DRAIN: RD_LAT cycles, rd_en=0; accumulator captures each returning
//    rd_data (pipeline of rd_en tracks valid). First valid sample loads acc,
//    next three update acc=max(acc,rd_data), signed compare.
//  - WRITE: 1 cycle, wr_en=1, wr_addr=r*OUT_DIM+c, wr_data=acc (see
//    CONFIGURATION). Then c increments; c wraps 3->0 with r+1.
//  - Window cost 4+RD_LAT+1 cycles; RD_LAT=1: 6 cycles/window, 96 cycles
//    from accepted start to final wr_en; done rises the cycle after it.
//  - wr_en never asserted twice for one address per pass; all 16 written in order 0..15.
//  - Ties: equal values leave acc unchanged (result identical either way).
//  - Extremes: -32768 and 32767 compared correctly; no overflow (no arithmetic).
//  - Reset mid-pass: pass aborted next cycle, all outputs to reset values,
//    no further wr_en; in-flight read data discarded.
//  - start same cycle as reset: reset wins.
// CONFIGURATION
//  - P2_RELU_EN defined: wr_data = (acc<0) ? 0 : acc (ReLU fused after max).
//  - P2_RELU_EN undefined: wr_data = acc unmodified. Timing identical both ways.
// STRUCTURE
//  - Package p2_pkg: IN_DIM/OUT_DIM/DATA_W defaults, pix_t signed typedef,
//    p2_state_t enum {IDLE, READ, DRAIN, WRITE, DONE}, address-width localparams.
//  - Sub-module p2_max_acc: load/update signed running max with valid input;
//    controller holds FSM, counters, read-valid shift register.
// TESTING
//  1. Ramp map pix[a]=a, start -> wr_data per window = bottom-right pixel
//     (addr 0 -> 9, addr 15 -> 63); done high at cycle 97 after start (RD_LAT=1).
//  2. All-negative map pix=-(a+1) -> addr0 gets -1; with P2_RELU_EN all 16 writes = 0.
//  3. Window holding {-32768,32767,0,-1} -> 32767; window all -32768 -> -32768.
//  4. start pulsed again at cycle 40 while busy -> ignored, exactly 16 writes,
//     addrs 0..15 in order; start in DONE -> done drops, second pass repeats.
//  5. reset asserted at cycle 30 mid-pass -> next cycle busy=0, rd_en=wr_en=0,
//     no writes after; new start -> full pass from addr 0.
//  6. RD_LAT=3 build -> 8 cycles/window, rd_addr sequence unchanged, results match model.

Source files
------------

// File: rtl/p2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : p2_pkg
//  Description : Shared definitions for the pooling-2 sequencer.
//                - Default feature-map geometry and pixel width.
//                - Signed pixel typedef.
//                - Controller state encoding.
//                - Default address widths for both RAM ports.
//  Revision    : 1.0  initial release
// ============================================================================
package p2_pkg;

    // Default geometry: an 8x8 conv-2 map pooled down to 4x4.
    localparam int c_IN_DIM  = 8;
    localparam int c_OUT_DIM = 4;
    localparam int c_DATA_W  = 16;
    localparam int c_RD_LAT  = 1;

    // Address widths for the two RAM ports (6 and 4 bits with the defaults).
    localparam int c_IN_AW   = $clog2(c_IN_DIM * c_IN_DIM);
    localparam int c_OUT_AW  = $clog2(c_OUT_DIM * c_OUT_DIM);

    typedef logic signed [c_DATA_W-1:0] pix_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } p2_state_t;

endpackage : p2_pkg
`default_nettype wire

// File: rtl/p2_max_acc.sv
`default_nettype none
// ============================================================================
//  Module      : p2_max_acc
//  Description : Signed running-max accumulator for one 2x2 window.
//                A valid sample with i_load set replaces the accumulator;
//                a valid sample without i_load replaces it only when it is
//                strictly greater (ties keep the held value).
//  Ports       : clk      clock
//                rst      synchronous active-high reset, clears accumulator
//                i_valid  sample present on i_data this cycle
//                i_load   sample is the first of its window
//                i_data   signed sample
//                o_acc    current running maximum
//  Revision    : 1.0  initial release
// ============================================================================
module p2_max_acc
    import p2_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic                     i_load,
    input  logic signed [DATA_W-1:0] i_data,
    output logic signed [DATA_W-1:0] o_acc
);

    logic signed [DATA_W-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_valid) begin
            // Both operands are declared signed, so this is a two's-complement
            // compare; no arithmetic is done, so the extremes cannot overflow.
            if (i_load || (i_data > r_acc)) begin
                r_acc <= i_data;
            end
        end
    end

    assign o_acc = r_acc;

endmodule : p2_max_acc
`default_nettype wire

// File: rtl/p2_pool_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : p2_pool_ctrl
//  Description : Pooling-2 sequencer. On start it walks the conv-2 map in
//                2x2 windows (row-major window order), reads the four pixels
//                of each window, keeps their signed maximum and writes one
//                result per window to the P2 RAM at address r*OUT_DIM+c.
//                Per window: READ (4 cycles) -> DRAIN (RD_LAT cycles) ->
//                WRITE (1 cycle).
//  Config      : P2_RELU_EN  when defined, negative pooled values are written
//                            as zero; timing is the same either way.
//  Ports       : clk      clock
//                reset    synchronous active-high reset
//                start    one-cycle pulse, accepted in IDLE or DONE only
//                busy     high while a pass is running
//                done     level, high after the last write of a pass
//                rd_en    conv-2 RAM read strobe
//                rd_addr  conv-2 RAM address, row*IN_DIM+col
//                rd_data  conv-2 RAM data, valid RD_LAT cycles after rd_en
//                wr_en    P2 RAM write strobe
//                wr_addr  P2 RAM address
//                wr_data  pooled value
//  Revision    : 1.0  initial release
// ============================================================================
module p2_pool_ctrl
    import p2_pkg::*;
#(
    parameter int IN_DIM  = c_IN_DIM,
    parameter int OUT_DIM = c_OUT_DIM,
    parameter int DATA_W  = c_DATA_W,
    parameter int RD_LAT  = c_RD_LAT
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 rd_en,
    output logic [$clog2(IN_DIM*IN_DIM)-1:0]     rd_addr,
    input  logic signed [DATA_W-1:0]             rd_data,
    output logic                                 wr_en,
    output logic [$clog2(OUT_DIM*OUT_DIM)-1:0]   wr_addr,
    output logic signed [DATA_W-1:0]             wr_data
);

    localparam int IN_AW  = $clog2(IN_DIM * IN_DIM);
    localparam int OUT_AW = $clog2(OUT_DIM * OUT_DIM);
    localparam int CNT_W  = $clog2(OUT_DIM);

    localparam logic [1:0]       c_READ_LAST  = 2'd3;
    localparam logic [1:0]       c_DRAIN_LAST = 2'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] c_WIN_LAST   = CNT_W'(OUT_DIM - 1);

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    p2_state_t        r_state;
    p2_state_t        w_state_nxt;
    logic [1:0]       r_phase;       // cycle index inside READ or DRAIN
    logic [1:0]       w_phase_nxt;
    logic [CNT_W-1:0] r_row;         // window row r
    logic [CNT_W-1:0] r_col;         // window column c
    logic [CNT_W-1:0] w_row_nxt;
    logic [CNT_W-1:0] w_col_nxt;

    logic             w_last_win;
    logic             w_rd_en;
    logic             w_rd_first;
    logic [IN_AW-1:0] w_base;
    logic [IN_AW-1:0] w_off;

    // Read-valid tracking: bit RD_LAT-1 lines up with the returning data.
    logic [RD_LAT-1:0]        r_vld;
    logic [RD_LAT-1:0]        r_first;
    logic                     w_smp_vld;
    logic                     w_smp_first;

    logic signed [DATA_W-1:0] w_acc;
    logic signed [DATA_W-1:0] w_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_phase <= 2'd0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    assign w_last_win = (r_row == c_WIN_LAST) && (r_col == c_WIN_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = READ;
                    w_phase_nxt = 2'd0;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end

            READ: begin
                if (r_phase == c_READ_LAST) begin
                    w_state_nxt = DRAIN;
                    w_phase_nxt = 2'd0;
                end else begin
                    w_phase_nxt = r_phase + 2'd1;
                end
            end

            DRAIN: begin
                if (r_phase == c_DRAIN_LAST) begin
                    w_state_nxt = WRITE;
                    w_phase_nxt = 2'd0;
                end else begin
                    w_phase_nxt = r_phase + 2'd1;
                end
            end

            WRITE: begin
                if (w_last_win) begin
                    // Counters return to zero so a later pass starts clean.
                    w_state_nxt = DONE;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end else begin
                    w_state_nxt = READ;
                    if (r_col == c_WIN_LAST) begin
                        w_col_nxt = '0;
                        w_row_nxt = r_row + 1'b1;
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read address generation: base = (2r)*IN_DIM + 2c, then the four
    // offsets top-left, top-right, bottom-left, bottom-right.
    // ------------------------------------------------------------------
    assign w_rd_en    = (r_state == READ);
    assign w_rd_first = w_rd_en && (r_phase == 2'd0);
    assign w_base     = IN_AW'(2 * IN_DIM * int'(r_row) + 2 * int'(r_col));

    always_comb begin
        w_off = '0;
        case (r_phase)
            2'd0:    w_off = '0;
            2'd1:    w_off = IN_AW'(1);
            2'd2:    w_off = IN_AW'(IN_DIM);
            default: w_off = IN_AW'(IN_DIM + 1);
        endcase
    end

    // ------------------------------------------------------------------
    // Read-valid pipeline. Reset clears it, so data from reads issued
    // before a reset never reaches the accumulator.
    // ------------------------------------------------------------------
    generate
        if (RD_LAT == 1) begin : g_vld_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld   <= '0;
                    r_first <= '0;
                end else begin
                    r_vld   <= w_rd_en;
                    r_first <= w_rd_first;
                end
            end
        end else begin : g_vld_latn
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld   <= '0;
                    r_first <= '0;
                end else begin
                    r_vld   <= {r_vld[RD_LAT-2:0], w_rd_en};
                    r_first <= {r_first[RD_LAT-2:0], w_rd_first};
                end
            end
        end
    endgenerate

    assign w_smp_vld   = r_vld[RD_LAT-1];
    assign w_smp_first = r_first[RD_LAT-1];

    p2_max_acc #(
        .DATA_W (DATA_W)
    ) u_max_acc (
        .clk     (clk),
        .rst     (reset),
        .i_valid (w_smp_vld),
        .i_load  (w_smp_first),
        .i_data  (rd_data),
        .o_acc   (w_acc)
    );

`ifdef P2_RELU_EN
    assign w_result = w_acc[DATA_W-1] ? '0 : w_acc;
`else
    assign w_result = w_acc;
`endif

    // ------------------------------------------------------------------
    // Outputs. Address and data buses are held at zero outside their
    // strobes so idle and reset values are all zero.
    // ------------------------------------------------------------------
    assign busy    = (r_state == READ) || (r_state == DRAIN) || (r_state == WRITE);
    assign done    = (r_state == DONE);
    assign rd_en   = w_rd_en;
    assign rd_addr = w_rd_en ? (w_base + w_off) : '0;
    assign wr_en   = (r_state == WRITE);
    assign wr_addr = wr_en ? OUT_AW'(int'(r_row) * OUT_DIM + int'(r_col)) : '0;
    assign wr_data = wr_en ? w_result : '0;

endmodule : p2_pool_ctrl
`default_nettype wire
